// File: rtl/rf_pkg.sv
// Shared constants for the register-file write-port arbiter.
package rf_pkg;
  localparam int DATA_W    = 16;
  localparam int REG_SEL_W = 3;
  localparam int NUM_REGS  = 1 << REG_SEL_W;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
endpackage

// File: rtl/rf_wr_arb_if.sv
// Requester handshakes plus register-file write controls for rf_wr_arb.
interface rf_wr_arb_if;
  import rf_pkg::*;

  logic                 a_req;
  logic [REG_SEL_W-1:0] a_sel;
  logic [DATA_W-1:0]    a_data;
  logic                 a_ack;
  logic                 b_req;
  logic [REG_SEL_W-1:0] b_sel;
  logic [DATA_W-1:0]    b_data;
  logic                 b_ack;
  logic                 rf_write;
  logic [REG_SEL_W-1:0] rf_writeregsel;
  logic [DATA_W-1:0]    rf_writedata;
  logic [NUM_REGS-1:0]  pend;
  logic                 err;

  modport master (
    output a_req, a_sel, a_data, b_req, b_sel, b_data,
    input  a_ack, b_ack, rf_write, rf_writeregsel, rf_writedata, pend, err
  );

  modport slave (
    input  a_req, a_sel, a_data, b_req, b_sel, b_data,
    output a_ack, b_ack, rf_write, rf_writeregsel, rf_writedata, pend, err
  );
endinterface

// File: rtl/rf_wr_buf.sv
// One-entry holding buffer in front of the shared write port.
module rf_wr_buf
  import rf_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 accept_i,
  input  logic                 grant_i,
  input  logic [REG_SEL_W-1:0] sel_i,
  input  logic [DATA_W-1:0]    data_i,
  output logic                 full_o,
  output logic [REG_SEL_W-1:0] sel_o,
  output logic [DATA_W-1:0]    data_o
);

  logic                 full_q, full_d;
  logic [REG_SEL_W-1:0] sel_q, sel_d;
  logic [DATA_W-1:0]    data_q, data_d;

  // Accept wins over grant so a granted entry can be replaced in the same cycle.
  always_comb begin
    full_d = full_q;
    sel_d  = sel_q;
    data_d = data_q;
    if (accept_i) begin
      full_d = 1'b1;
      sel_d  = sel_i;
      data_d = data_i;
    end else if (grant_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      sel_q  <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      sel_q  <= sel_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign sel_o  = sel_q;
  assign data_o = data_q;

endmodule

// File: rtl/rf_wr_arb.sv
// Oldest-first / round-robin arbiter for two writers sharing one register-file
// write port, with registered write controls, pending mask and collision flag.
module rf_wr_arb
  import rf_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  rf_wr_arb_if.slave  bus
);

  logic                 full_a, full_b;
  logic [REG_SEL_W-1:0] sel_a, sel_b;
  logic [DATA_W-1:0]    data_a, data_b;
  logic                 grant_a, grant_b, tie_break;
  logic                 acc_a, acc_b;

  logic                 rr_q, rr_d;
  logic                 a_older_q, a_older_d;
  logic                 tie_q, tie_d;
  logic                 err_q, err_d;
  logic                 wr_q, wr_d;
  logic [REG_SEL_W-1:0] wsel_q, wsel_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [NUM_REGS-1:0]  pend_w;

  rf_wr_buf u_buf_a (
    .clk(clk), .rst(rst), .accept_i(acc_a), .grant_i(grant_a),
    .sel_i(bus.a_sel), .data_i(bus.a_data),
    .full_o(full_a), .sel_o(sel_a), .data_o(data_a)
  );

  rf_wr_buf u_buf_b (
    .clk(clk), .rst(rst), .accept_i(acc_b), .grant_i(grant_b),
    .sel_i(bus.b_sel), .data_i(bus.b_data),
    .full_o(full_b), .sel_o(sel_b), .data_o(data_b)
  );

  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    tie_break = 1'b0;
    if (full_a && full_b) begin
      if (tie_q) begin
        tie_break = 1'b1;
        grant_a   = (rr_q == REQ_A);
        grant_b   = (rr_q == REQ_B);
      end else begin
        grant_a = a_older_q;
        grant_b = !a_older_q;
      end
    end else begin
      grant_a = full_a;
      grant_b = full_b;
    end
  end

  assign bus.a_ack = !full_a || grant_a;
  assign bus.b_ack = !full_b || grant_b;
  assign acc_a     = bus.a_req && bus.a_ack;
  assign acc_b     = bus.b_req && bus.b_ack;

  // A lone accept makes the other (still-buffered) entry the older one.
  always_comb begin
    rr_d      = tie_break ? !rr_q : rr_q;
    a_older_d = a_older_q;
    tie_d     = tie_q;
    if (acc_a && acc_b) begin
      tie_d = 1'b1;
    end else if (acc_a) begin
      tie_d     = 1'b0;
      a_older_d = 1'b0;
    end else if (acc_b) begin
      tie_d     = 1'b0;
      a_older_d = 1'b1;
    end
    err_d   = acc_a && acc_b && (bus.a_sel == bus.b_sel);
    wr_d    = grant_a || grant_b;
    wsel_d  = wsel_q;
    wdata_d = wdata_q;
    if (grant_a) begin
      wsel_d  = sel_a;
      wdata_d = data_a;
    end else if (grant_b) begin
      wsel_d  = sel_b;
      wdata_d = data_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q      <= REQ_A;
      a_older_q <= 1'b0;
      tie_q     <= 1'b0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      wsel_q    <= '0;
      wdata_q   <= '0;
    end else begin
      rr_q      <= rr_d;
      a_older_q <= a_older_d;
      tie_q     <= tie_d;
      err_q     <= err_d;
      wr_q      <= wr_d;
      wsel_q    <= wsel_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    pend_w = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pend_w[i] = (full_a && (sel_a == REG_SEL_W'(i))) ||
                  (full_b && (sel_b == REG_SEL_W'(i))) ||
                  (wr_q && (wsel_q == REG_SEL_W'(i)));
    end
  end

  assign bus.rf_write       = wr_q;
  assign bus.rf_writeregsel = wsel_q;
  assign bus.rf_writedata   = wdata_q;
  assign bus.pend           = pend_w;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_rf_wr_arb.sv
// Directed bench for rf_wr_arb: hand-computed vectors, immediate assertions.
module tb_rf_wr_arb;
  import rf_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   na, nb;
  logic [DATA_W-1:0] rf_model [NUM_REGS];

  rf_wr_arb_if bus ();

  rf_wr_arb dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = !clk;

  always @(posedge clk)
    if (rst && bus.rf_write) rf_model[bus.rf_writeregsel] <= bus.rf_writedata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [REG_SEL_W-1:0] sel, input logic [DATA_W-1:0] data);
    chk({tag, "_we"}, 32'(bus.rf_write), 32'd1);
    chk({tag, "_sel"}, 32'(bus.rf_writeregsel), 32'(sel));
    chk({tag, "_data"}, 32'(bus.rf_writedata), 32'(data));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.a_req = 1'b0; bus.a_sel = '0; bus.a_data = '0;
    bus.b_req = 1'b0; bus.b_sel = '0; bus.b_data = '0;
    #12;
    chk("rst_a_ack", 32'(bus.a_ack), 32'd1);
    chk("rst_b_ack", 32'(bus.b_ack), 32'd1);
    chk("rst_we", 32'(bus.rf_write), 32'd0);
    chk("rst_sel", 32'(bus.rf_writeregsel), 32'd0);
    chk("rst_data", 32'(bus.rf_writedata), 32'd0);
    chk("rst_pend", 32'(bus.pend), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    cyc();
    rst = 1'b1;

    // Single write from A.
    bus.a_req = 1'b1; bus.a_sel = 3'd3; bus.a_data = 16'h1234;
    chk("single_ack", 32'(bus.a_ack), 32'd1);
    cyc();
    bus.a_req = 1'b0;
    chk("single_pend1", 32'(bus.pend), 32'h08);
    chk("single_we1", 32'(bus.rf_write), 32'd0);
    cyc();
    chk_wr("single_c2", 3'd3, 16'h1234);
    chk("single_pend2", 32'(bus.pend), 32'h08);
    cyc();
    chk("single_we3", 32'(bus.rf_write), 32'd0);
    chk("single_pend3", 32'(bus.pend), 32'h00);
    chk("single_r3", 32'(rf_model[3]), 32'h1234);

    // Tie, then the pointer favours B on the next tie.
    bus.a_req = 1'b1; bus.a_sel = 3'd1; bus.a_data = 16'h00AA;
    bus.b_req = 1'b1; bus.b_sel = 3'd2; bus.b_data = 16'h00BB;
    cyc();
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    chk("tie1_a_ack", 32'(bus.a_ack), 32'd1);
    chk("tie1_b_ack", 32'(bus.b_ack), 32'd0);
    chk("tie1_pend", 32'(bus.pend), 32'h06);
    cyc();
    chk_wr("tie1_c2", 3'd1, 16'h00AA);
    cyc();
    chk_wr("tie1_c3", 3'd2, 16'h00BB);
    cyc();
    chk("tie1_idle", 32'(bus.rf_write), 32'd0);
    cyc();
    bus.a_req = 1'b1; bus.a_sel = 3'd1; bus.a_data = 16'h0011;
    bus.b_req = 1'b1; bus.b_sel = 3'd2; bus.b_data = 16'h0022;
    cyc();
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    chk("tie2_a_ack", 32'(bus.a_ack), 32'd0);
    chk("tie2_b_ack", 32'(bus.b_ack), 32'd1);
    cyc();
    chk_wr("tie2_c7", 3'd2, 16'h0022);
    cyc();
    chk_wr("tie2_c8", 3'd1, 16'h0011);
    cyc();
    chk("tie2_idle", 32'(bus.rf_write), 32'd0);

    // Age ordering: pointer is back at A.
    bus.a_req = 1'b1; bus.a_sel = 3'd1; bus.a_data = 16'h00A1;
    bus.b_req = 1'b1; bus.b_sel = 3'd2; bus.b_data = 16'h00B1;
    cyc();
    bus.a_sel = 3'd4; bus.a_data = 16'h0044; bus.b_req = 1'b0;
    chk("age_a_ack1", 32'(bus.a_ack), 32'd1);
    chk("age_b_ack1", 32'(bus.b_ack), 32'd0);
    cyc();
    bus.a_req = 1'b0;
    chk("age_a_ack2", 32'(bus.a_ack), 32'd0);
    chk("age_b_ack2", 32'(bus.b_ack), 32'd1);
    chk_wr("age_c2", 3'd1, 16'h00A1);
    cyc();
    chk_wr("age_c3", 3'd2, 16'h00B1);
    cyc();
    chk_wr("age_c4", 3'd4, 16'h0044);
    cyc();
    chk("age_idle", 32'(bus.rf_write), 32'd0);

    // Pointer is at B now; this tie returns it to A.
    bus.a_req = 1'b1; bus.a_sel = 3'd6; bus.a_data = 16'h0066;
    bus.b_req = 1'b1; bus.b_sel = 3'd7; bus.b_data = 16'h0077;
    cyc();
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    cyc();
    chk_wr("rr_c2", 3'd7, 16'h0077);
    cyc();
    chk_wr("rr_c3", 3'd6, 16'h0066);
    cyc();

    // Same-select collision with the pointer at A.
    bus.a_req = 1'b1; bus.a_sel = 3'd5; bus.a_data = 16'h0001;
    bus.b_req = 1'b1; bus.b_sel = 3'd5; bus.b_data = 16'h0002;
    chk("col_err0", 32'(bus.err), 32'd0);
    cyc();
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    chk("col_err1", 32'(bus.err), 32'd1);
    chk("col_pend1", 32'(bus.pend), 32'h20);
    cyc();
    chk("col_err2", 32'(bus.err), 32'd0);
    chk_wr("col_c2", 3'd5, 16'h0001);
    cyc();
    chk_wr("col_c3", 3'd5, 16'h0002);
    cyc();
    chk("col_r5", 32'(rf_model[5]), 32'h0002);
    chk("col_pend4", 32'(bus.pend), 32'h00);

    // Saturation, entering with the pointer at B: B wins the opening tie.
    na = 0; nb = 0;
    bus.a_req = 1'b1; bus.a_sel = 3'd1;
    bus.b_req = 1'b1; bus.b_sel = 3'd2;
    for (int c = 0; c < 24; c++) begin
      if (c == 20) begin
        bus.a_req = 1'b0; bus.b_req = 1'b0;
      end
      bus.a_data = 16'hA000 + 16'(na);
      bus.b_data = 16'hB000 + 16'(nb);
      if (c < 20) begin
        chk("sat_a_ack", 32'(bus.a_ack), (c == 0 || c % 2 == 0) ? 32'd1 : 32'd0);
        chk("sat_b_ack", 32'(bus.b_ack), (c == 0 || c % 2 == 1) ? 32'd1 : 32'd0);
      end
      if (c >= 2 && c <= 22) begin
        if (c % 2 == 0) chk_wr("sat_b", 3'd2, 16'hB000 + 16'((c - 2) / 2));
        else            chk_wr("sat_a", 3'd1, 16'hA000 + 16'((c - 3) / 2));
      end else if (c == 23) begin
        chk("sat_idle", 32'(bus.rf_write), 32'd0);
      end
      if (bus.a_req && bus.a_ack) na++;
      if (bus.b_req && bus.b_ack) nb++;
      cyc();
    end

    // Asynchronous reset with both buffers occupied and a write on the port.
    bus.a_req = 1'b1; bus.a_sel = 3'd3; bus.a_data = 16'h0333;
    bus.b_req = 1'b1; bus.b_sel = 3'd4; bus.b_data = 16'h0444;
    cyc();
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    cyc();
    chk("mid_we_before", 32'(bus.rf_write), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_we", 32'(bus.rf_write), 32'd0);
    chk("mid_pend", 32'(bus.pend), 32'h00);
    chk("mid_a_ack", 32'(bus.a_ack), 32'd1);
    chk("mid_b_ack", 32'(bus.b_ack), 32'd1);
    chk("mid_err", 32'(bus.err), 32'd0);
    cyc();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("post_rst_we", 32'(bus.rf_write), 32'd0);
      chk("post_rst_pend", 32'(bus.pend), 32'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
